// File: rtl/any1_mem_aligner.sv
`default_nettype none
// ============================================================================
// Module      : any1_mem_aligner
// Description : Lane-shifts one load/store onto a 256-bit bus, splitting
//               line-crossing accesses into two bus cycles, and right-justifies
//               load data into the result.
// Revision    : 1.0 - initial release
// ============================================================================
module any1_mem_aligner #(
    parameter int BUS_TO = 255
) (
    input  logic         rst_i,
    input  logic         clk_i,
    input  logic         req_i,
    input  logic         we_i,
    input  logic [31:0]  adr_i,
    input  logic [31:0]  sel_i,
    input  logic [255:0] dat_i,
    output logic         busy_o,
    output logic         rdy_o,
    output logic         err_o,
    output logic [255:0] res_o,
    output logic         cyc_o,
    output logic         stb_o,
    output logic         we_o,
    output logic [31:0]  adr_o,
    output logic [31:0]  sel_o,
    output logic [255:0] dat_o,
    input  logic         ack_i,
    input  logic         err_i,
    input  logic [255:0] bdat_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B1   = 3'd1,
        S_GAP  = 3'd2,
        S_B2   = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic           ld_we_q, ld_we_d;
    logic [26:0]    line_q, line_d;
    logic [4:0]     sh_q, sh_d;
    logic [31:0]    selhi_q, selhi_d;
    logic [255:0]   dathi_q, dathi_d;
    logic [255:0]   lo_q, lo_d;
    logic [9:0]     cnt_q, cnt_d;
    logic           busy_q, busy_d, rdy_q, rdy_d, err_q, err_d;
    logic           cyc_q, cyc_d, stb_q, stb_d, bwe_q, bwe_d;
    logic [31:0]    adr_q, adr_d, sel_q, sel_d;
    logic [255:0]   dat_q, dat_d, res_q, res_d;

    logic [63:0]    w_sel64;
    logic [511:0]   w_dat512;
    logic [255:0]   w_hi, w_lo;
    logic [511:0]   w_rd;
    logic           w_timeout;
    logic           fin_ok, fin_err;

    assign w_sel64   = {32'b0, sel_i} << adr_i[4:0];
    assign w_dat512  = {256'b0, dat_i} << {adr_i[4:0], 3'b000};
    // Single-line accesses realign with an all-zero upper half.
    assign w_hi      = (state_q == S_B2) ? bdat_i : '0;
    assign w_lo      = (state_q == S_B2) ? lo_q : bdat_i;
    assign w_rd      = {w_hi, w_lo} >> {sh_q, 3'b000};
    assign w_timeout = (cnt_q == 10'(BUS_TO - 1));

    always_comb begin
        state_d = state_q;
        ld_we_d = ld_we_q;
        line_d  = line_q;
        sh_d    = sh_q;
        selhi_d = selhi_q;
        dathi_d = dathi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        rdy_d   = 1'b0;
        err_d   = 1'b0;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        bwe_d   = bwe_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        res_d   = res_q;
        fin_ok  = 1'b0;
        fin_err = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    ld_we_d = we_i;
                    line_d  = adr_i[31:5];
                    sh_d    = adr_i[4:0];
                    selhi_d = w_sel64[63:32];
                    dathi_d = w_dat512[511:256];
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    if (sel_i == 32'b0) begin
                        fin_ok = 1'b1;
                        if (!we_i) res_d = '0;
                    end else begin
                        state_d = S_B1;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        bwe_d   = we_i;
                        adr_d   = {adr_i[31:5], 5'b0};
                        sel_d   = w_sel64[31:0];
                        dat_d   = w_dat512[255:0];
                    end
                end
            end
            S_B1, S_B2: begin
                if (err_i) begin
                    fin_err = 1'b1;
                end else if (ack_i) begin
                    if (state_q == S_B1 && selhi_q != 32'b0) begin
                        state_d = S_GAP;
                        stb_d   = 1'b0;
                        lo_d    = bdat_i;
                    end else begin
                        fin_ok = 1'b1;
                        if (!ld_we_q) res_d = w_rd[255:0];
                    end
                end else if (w_timeout) begin
                    fin_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            S_GAP: begin
                state_d = S_B2;
                stb_d   = 1'b1;
                cnt_d   = '0;
                adr_d   = {line_q + 27'd1, 5'b0};
                sel_d   = selhi_q;
                dat_d   = dathi_q;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (fin_ok || fin_err) begin
            state_d = fin_ok ? S_DONE : S_ERR;
            rdy_d   = fin_ok;
            err_d   = fin_err;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            bwe_d   = 1'b0;
            adr_d   = '0;
            sel_d   = '0;
            dat_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ld_we_q <= 1'b0;
            line_q  <= '0;
            sh_q    <= '0;
            selhi_q <= '0;
            dathi_q <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            bwe_q   <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ld_we_q <= ld_we_d;
            line_q  <= line_d;
            sh_q    <= sh_d;
            selhi_q <= selhi_d;
            dathi_q <= dathi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            bwe_q   <= bwe_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            res_q   <= res_d;
        end
    end

    assign busy_o = busy_q;
    assign rdy_o  = rdy_q;
    assign err_o  = err_q;
    assign res_o  = res_q;
    assign cyc_o  = cyc_q;
    assign stb_o  = stb_q;
    assign we_o   = bwe_q;
    assign adr_o  = adr_q;
    assign sel_o  = sel_q;
    assign dat_o  = dat_q;

endmodule
`default_nettype wire
